// File: rtl/car_link_pkg.sv
// Shared definitions for the FPGA <-> simulator serial link (command TX and future detector RX).
package car_link_pkg;

  localparam int CMD_FWD   = 0;
  localparam int CMD_BWD   = 1;
  localparam int CMD_LEFT  = 2;
  localparam int CMD_RIGHT = 3;
  localparam int CMD_BRAKE = 4;
  localparam int CMD_POWER = 5;

  localparam int DEFAULT_BAUD_DIV       = 10417;
  localparam int DEFAULT_REFRESH_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } link_state_t;

  // Bits 7:6 are reserved and always transmitted as zero.
  function automatic logic [7:0] pack_cmd(input logic fwd, input logic bwd,
                                          input logic left, input logic right,
                                          input logic brake, input logic power);
    logic [7:0] v;
    v            = '0;
    v[CMD_FWD]   = fwd;
    v[CMD_BWD]   = bwd;
    v[CMD_LEFT]  = left;
    v[CMD_RIGHT] = right;
    v[CMD_BRAKE] = brake;
    v[CMD_POWER] = power;
    return v;
  endfunction

endpackage

// File: rtl/car_cmd_uart_tx_baud_tick_gen.sv
// Bit-time divisor: counts 0..BAUD_DIV-1, pulses tick on the last count, restarts on clear.
module baud_tick_gen
  import car_link_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/car_cmd_uart_tx.sv
// Packs the driving command levels into one byte and sends it as an 8N1 frame (LSB first)
// on every command change and periodically as a keep-alive.
module car_cmd_uart_tx
  import car_link_pkg::*;
#(
  parameter int BAUD_DIV       = DEFAULT_BAUD_DIV,
  parameter int REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic move_forward,
  input  logic move_backward,
  input  logic turn_left,
  input  logic turn_right,
  input  logic brake_on,
  input  logic power_on,
  output logic tx,
  output logic busy,
  output logic frame_sent
);

  localparam int               REF_W    = $clog2(REFRESH_CYCLES);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  // Raising pending one count early lets the keep-alive frame start exactly
  // REFRESH_CYCLES after the previous frame start.
  localparam logic [REF_W-1:0] REF_DUE  = REF_W'(REFRESH_CYCLES - 2);

  link_state_t      r_state;
  link_state_t      w_state_nxt;
  logic [7:0]       w_cmd_vec;
  logic [7:0]       r_shift;
  logic [7:0]       r_last_sent;
  logic             r_pending;
  logic [REF_W-1:0] r_refresh;
  logic [2:0]       r_bit_cnt;
  logic             w_tick;
  logic             w_start;
  logic             w_baud_clear;
  logic             w_tx;
  logic             w_busy;
  logic             w_frame_sent;

  assign w_cmd_vec = pack_cmd(move_forward, move_backward, turn_left,
                              turn_right, brake_on, power_on);

  assign w_start      = (r_state == IDLE) && enable && r_pending;
  assign w_baud_clear = (r_state == IDLE);

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_baud_clear),
    .tick  (w_tick)
  );

  // Frame start beats any simultaneous set condition; last_sent already holds the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b1;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end else if ((w_cmd_vec != r_last_sent) || (r_refresh >= REF_DUE)) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
    end else if (w_start) begin
      r_refresh <= '0;
    end else if (r_refresh != REF_LAST) begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_sent <= 8'h00;
    end else if (w_start) begin
      r_last_sent <= w_cmd_vec;
    end
  end

  // The payload needs no reset: it is always loaded before the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_shift <= w_cmd_vec;
    end else if ((r_state == DATA) && w_tick) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
    end else if (w_start) begin
      r_bit_cnt <= 3'd0;
    end else if ((r_state == DATA) && w_tick) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tx         = 1'b1;
    w_busy       = 1'b1;
    w_frame_sent = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_start) begin
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_tick) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_tick && (r_bit_cnt == 3'd7)) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_frame_sent = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
    endcase
  end

  assign tx         = w_tx;
  assign busy       = w_busy;
  assign frame_sent = w_frame_sent;

endmodule
